// File: rtl/noc_pkg.sv
// noc_pkg: NoC opcodes, header bit layout, FSM state type and header packing shared by encoder and decoder
package noc_pkg;

    localparam logic [2:0] OP_MPUT   = 3'd4;
    localparam logic [2:0] OP_MGET   = 3'd5;
    localparam logic [2:0] OP_MLOAD  = 3'd6;
    localparam logic [2:0] OP_MSTORE = 3'd7;

    // Header beat: {3'b0, hl, code, 1'b0, src[5:0], field[11:0], dest[5:0]}
    localparam int HDR_DEST_LSB  = 0;
    localparam int HDR_FIELD_LSB = 6;
    localparam int HDR_SRC_LSB   = 18;
    localparam int HDR_CODE_LSB  = 25;
    localparam int HDR_HL_BIT    = 28;

    // Long-header burst length position, in header bit numbering
    localparam int LEN_PUT_LSB = 8;
    localparam int LEN_GET_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_PAYLOAD,
        ST_RET,
        ST_WAIT_RSP
    } enc_state_e;

    function automatic logic is_put(input logic [2:0] code);
        return code == OP_MPUT || code == OP_MSTORE;
    endfunction

    function automatic logic [11:0] hdr_field(input logic hl, input logic [2:0] code,
                                              input logic [11:0] offset, input logic [3:0] len_log2);
        logic [11:0] f;
        f = is_put(code) ? 12'(len_log2) << (LEN_PUT_LSB - HDR_FIELD_LSB)
                         : 12'(len_log2) << (LEN_GET_LSB - HDR_FIELD_LSB);
        return hl ? f : offset;
    endfunction

    function automatic logic [31:0] hdr_pack(input logic hl, input logic [2:0] code, input logic [5:0] src,
                                             input logic [11:0] field, input logic [5:0] dest);
        logic [31:0] h;
        h = '0;
        h[HDR_DEST_LSB +: 6]  = dest;
        h[HDR_FIELD_LSB +: 12] = field;
        h[HDR_SRC_LSB +: 6]   = src;
        h[HDR_CODE_LSB +: 3]  = code;
        h[HDR_HL_BIT]         = hl;
        return h;
    endfunction

endpackage

// File: rtl/noc_encoder.sv
// noc_encoder: turns processor remote-memory requests into NoC AXI-stream packets; NOC_ENC_TIMEOUT_EN adds a response timeout
module noc_encoder
    import noc_pkg::*;
#(
    parameter int BW          = 32,
    parameter int BWB         = BW / 8,
    parameter int XY_SZ       = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk_ctrl,
    input  logic                 clk_ctrl_rst,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_code,
    input  logic                 req_hl,
    input  logic [5:0]           req_dest,
    input  logic [11:0]          req_offset,
    input  logic [3:0]           req_len_log2,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_ret,
    input  logic                 wr_valid,
    input  logic [BW-1:0]        wr_data,
    output logic                 wr_ready,
    output logic                 m_TVALID,
    output logic [BW-1:0]        m_TDATA,
    output logic [BWB-1:0]       m_TKEEP,
    output logic                 m_TLAST,
    input  logic                 m_TREADY,
    input  logic                 unblock,
    output logic                 core_wait,
    output logic                 rsp_timeout
);

    enc_state_e  state_q, state_d;
    logic [2:0]  code_q, code_d;
    logic        hl_q, hl_d;
    logic [31:0] hdr_q, hdr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ret_q, ret_d;
    logic [15:0] cnt_q, cnt_d;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef NOC_ENC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign m_TKEEP   = '1;
    assign core_wait = (state_q != ST_IDLE) && (code_q == OP_MLOAD || code_q == OP_MSTORE);

    // Next state, request latching and stream outputs; payload passes straight through from wr_* unbuffered
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        hl_d     = hl_q;
        hdr_d    = hdr_q;
        addr_d   = addr_q;
        ret_d    = ret_q;
        cnt_d    = cnt_q;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        m_TVALID  = 1'b0;
        m_TDATA   = '0;
        m_TLAST   = 1'b0;
`ifdef NOC_ENC_TIMEOUT_EN
        tmo_d         = '0;
        rsp_timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready = !clk_ctrl_rst;
                if (req_valid) begin
                    code_d  = req_code;
                    hl_d    = req_hl;
                    hdr_d   = hdr_pack(req_hl, req_code, 6'(HsrcId),
                                       hdr_field(req_hl, req_code, req_offset, req_len_log2), req_dest);
                    addr_d  = req_addr;
                    ret_d   = req_ret;
                    cnt_d   = req_hl ? 16'(1) << req_len_log2 : 16'd1;
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (!code_q[2]) begin
                    state_d = ST_IDLE;
                end else begin
                    m_TVALID = 1'b1;
                    m_TDATA  = BW'(hdr_q);
                    if (m_TREADY)
                        state_d = hl_q ? ST_HDR2 : (is_put(code_q) ? ST_PAYLOAD : ST_RET);
                end
            end
            ST_HDR2: begin
                m_TVALID = 1'b1;
                m_TDATA  = BW'(addr_q);
                if (m_TREADY)
                    state_d = is_put(code_q) ? ST_PAYLOAD : ST_RET;
            end
            ST_PAYLOAD: begin
                m_TVALID = wr_valid;
                wr_ready = m_TREADY;
                m_TDATA  = wr_data;
                m_TLAST  = cnt_q == 16'd1;
                if (wr_valid && m_TREADY) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1)
                        state_d = (code_q == OP_MSTORE) ? ST_WAIT_RSP : ST_IDLE;
                end
            end
            ST_RET: begin
                m_TVALID = 1'b1;
                m_TDATA  = BW'(ret_q);
                m_TLAST  = 1'b1;
                if (m_TREADY)
                    state_d = (code_q == OP_MLOAD) ? ST_WAIT_RSP : ST_IDLE;
            end
            ST_WAIT_RSP: begin
                if (unblock)
                    state_d = ST_IDLE;
`ifdef NOC_ENC_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
                if (!unblock && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request latches; reset abandons any packet in flight at once
    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            hl_q    <= 1'b0;
            hdr_q   <= '0;
            addr_q  <= '0;
            ret_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hl_q    <= hl_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef NOC_ENC_TIMEOUT_EN
    // Response wait counter and registered one-cycle timeout pulse
    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst) begin
            tmo_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_noc_encoder.sv
// tb_noc_encoder: scoreboard bench for noc_encoder; timeout checks follow NOC_ENC_TIMEOUT_EN
module tb_noc_encoder;

    logic        clk_ctrl = 1'b0;
    logic        clk_ctrl_rst = 1'b1;
    logic [5:0]  HsrcId;
    logic        req_valid, req_ready;
    logic [2:0]  req_code;
    logic        req_hl;
    logic [5:0]  req_dest;
    logic [11:0] req_offset;
    logic [3:0]  req_len_log2;
    logic [31:0] req_addr, req_ret;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        m_TVALID, m_TLAST, m_TREADY;
    logic [31:0] m_TDATA;
    logic [3:0]  m_TKEEP;
    logic        unblock, core_wait, rsp_timeout;

    noc_encoder #(.BW(32), .BWB(4), .XY_SZ(3), .TIMEOUT_CYC(16)) dut (
        .clk_ctrl(clk_ctrl), .clk_ctrl_rst(clk_ctrl_rst), .HsrcId(HsrcId),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code), .req_hl(req_hl),
        .req_dest(req_dest), .req_offset(req_offset), .req_len_log2(req_len_log2),
        .req_addr(req_addr), .req_ret(req_ret),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .m_TVALID(m_TVALID), .m_TDATA(m_TDATA), .m_TKEEP(m_TKEEP), .m_TLAST(m_TLAST), .m_TREADY(m_TREADY),
        .unblock(unblock), .core_wait(core_wait), .rsp_timeout(rsp_timeout)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] wq[$];
    beat_t       mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          toggle_en = 1'b0;
    bit          cw_seen = 1'b0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endfunction

    task automatic expect_beat(input logic [31:0] d, input logic l);
        exp_q.push_back('{d, l});
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared
    always @(negedge clk_ctrl) begin
        if (!clk_ctrl_rst && m_TVALID && m_TREADY) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%08h last %0b, expected no beat", m_TDATA, m_TLAST);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", m_TDATA, mon_e.data);
                chk("beat_last", 32'(m_TLAST), 32'(mon_e.last));
                chk("beat_keep", 32'(m_TKEEP), 32'hF);
            end
        end
        if (core_wait) cw_seen = 1'b1;
    end

    // Write-stream feeder: presents wq words, advancing only on a handshake
    initial begin : feeder
        bit hs;
        bit tog;
        wr_valid = 1'b0;
        wr_data  = '0;
        tog      = 1'b0;
        forever begin
            @(negedge clk_ctrl);
            hs = wr_valid && wr_ready;
            @(posedge clk_ctrl);
            #1;
            if (hs && wq.size() > 0) void'(wq.pop_front());
            tog = !tog;
            if (wq.size() > 0 && (!toggle_en || tog)) begin
                wr_valid = 1'b1;
                wr_data  = wq[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    task automatic send_req(input logic [2:0] code, input logic hl, input logic [5:0] dest, input logic [11:0] off,
                            input logic [3:0] len, input logic [31:0] addr, input logic [31:0] ret);
        bit ok;
        ok = 1'b0;
        @(posedge clk_ctrl);
        #1;
        req_code = code; req_hl = hl; req_dest = dest; req_offset = off;
        req_len_log2 = len; req_addr = addr; req_ret = ret; req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_ctrl);
            ok = req_ready;
        end
        @(posedge clk_ctrl);
        #1;
        req_valid = 1'b0;
        chk("req_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_empty(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge clk_ctrl);
            done = exp_q.size() == 0;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        bit to_seen;
        bit cw_all;
        int n;
        int hs_cnt;
        HsrcId = 6'h12; req_valid = 1'b0; req_code = '0; req_hl = 1'b0; req_dest = '0; req_offset = '0;
        req_len_log2 = '0; req_addr = '0; req_ret = '0; m_TREADY = 1'b1; unblock = 1'b0;

        // reset state
        repeat (2) @(negedge clk_ctrl);
        chk("rst_tvalid", 32'(m_TVALID), 0);
        chk("rst_tlast", 32'(m_TLAST), 0);
        chk("rst_tdata", m_TDATA, 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_core_wait", 32'(core_wait), 0);
        chk("rst_timeout", 32'(rsp_timeout), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        clk_ctrl_rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 1);

        // MPUT short header, one payload beat
        cw_seen = 1'b0;
        wq.push_back(32'hCAFE0001);
        expect_beat(32'h08480409, 1'b0);
        expect_beat(32'hCAFE0001, 1'b1);
        send_req(3'd4, 1'b0, 6'h09, 12'h010, 4'd0, 32'h0, 32'h0);
        wait_empty(50);
        repeat (2) @(negedge clk_ctrl);
        chk("mput_idle", 32'(req_ready), 1);
        chk("mput_no_wait", 32'(cw_seen), 0);

        // MGET long header: header, address, return beat; offset must not leak into header
        expect_beat(32'h1A482009, 1'b0);
        expect_beat(32'h00000100, 1'b0);
        expect_beat(32'hDEADBEEF, 1'b1);
        send_req(3'd5, 1'b1, 6'h09, 12'hFFF, 4'd2, 32'h100, 32'hDEADBEEF);
        wait_empty(50);
        repeat (2) @(negedge clk_ctrl);
        chk("mget_idle", 32'(req_ready), 1);

        // header held stable under backpressure, no write accept meanwhile
        m_TREADY = 1'b0;
        wq.push_back(32'h0000BEEF);
        expect_beat(32'h084AAF3F, 1'b0);
        expect_beat(32'h0000BEEF, 1'b1);
        send_req(3'd4, 1'b0, 6'h3F, 12'hABC, 4'd0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_ctrl);
            chk("hold_valid", 32'(m_TVALID), 1);
            chk("hold_data", m_TDATA, 32'h084AAF3F);
            chk("hold_wr_ready", 32'(wr_ready), 0);
        end
        @(posedge clk_ctrl);
        #1;
        m_TREADY = 1'b1;
        wait_empty(50);
        repeat (2) @(negedge clk_ctrl);

        // unknown opcode dropped, back to IDLE next cycle
        send_req(3'd2, 1'b0, 6'h01, 12'h001, 4'd0, 32'h0, 32'h0);
        @(negedge clk_ctrl);
        chk("unk_busy", 32'(req_ready), 0);
        chk("unk_no_valid", 32'(m_TVALID), 0);
        @(negedge clk_ctrl);
        chk("unk_idle", 32'(req_ready), 1);

        // MSTORE 8-beat burst, wr_valid toggling, early unblock ignored
        toggle_en = 1'b1;
        expect_beat(32'h1E480305, 1'b0);
        expect_beat(32'h00002000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            wq.push_back(32'hA0000000 + 32'(k));
            expect_beat(32'hA0000000 + 32'(k), k == 7);
        end
        send_req(3'd7, 1'b1, 6'h05, 12'h000, 4'd3, 32'h2000, 32'h0);
        unblock = 1'b1;
        @(posedge clk_ctrl);
        #1;
        unblock = 1'b0;
        wait_empty(100);
        repeat (3) @(negedge clk_ctrl);
        chk("mstore_wait", 32'(core_wait), 1);
        chk("mstore_busy", 32'(req_ready), 0);
        @(posedge clk_ctrl);
        #1;
        unblock = 1'b1;
        @(negedge clk_ctrl);
        chk("mstore_wait_unblk", 32'(core_wait), 1);
        @(posedge clk_ctrl);
        #1;
        unblock = 1'b0;
        @(negedge clk_ctrl);
        chk("mstore_idle", 32'(req_ready), 1);
        chk("mstore_released", 32'(core_wait), 0);
        toggle_en = 1'b0;

        // MLOAD with no unblock
        expect_beat(32'h0C480001, 1'b0);
        expect_beat(32'h55AA55AA, 1'b1);
        send_req(3'd6, 1'b0, 6'h01, 12'h000, 4'd0, 32'h0, 32'h55AA55AA);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk_ctrl);
            found = m_TVALID && m_TREADY && m_TLAST;
        end
        chk("mload_ret_seen", 32'(found), 1);
        @(posedge clk_ctrl);
`ifdef NOC_ENC_TIMEOUT_EN
        n = 0;
        for (int k = 1; k <= 100 && n == 0; k++) begin
            @(posedge clk_ctrl);
            @(negedge clk_ctrl);
            if (rsp_timeout) n = k;
        end
        chk("timeout_delay", 32'(n), 32'd16);
        chk("timeout_released", 32'(core_wait), 0);
        chk("timeout_idle", 32'(req_ready), 1);
        @(negedge clk_ctrl);
        chk("timeout_pulse_len", 32'(rsp_timeout), 0);
`else
        to_seen = 1'b0;
        cw_all  = 1'b1;
        repeat (40) begin
            @(negedge clk_ctrl);
            if (rsp_timeout) to_seen = 1'b1;
            if (!core_wait) cw_all = 1'b0;
        end
        chk("no_timeout", 32'(to_seen), 0);
        chk("mload_wait_hold", 32'(cw_all), 1);
        @(posedge clk_ctrl);
        #1;
        unblock = 1'b1;
        @(posedge clk_ctrl);
        #1;
        unblock = 1'b0;
        @(negedge clk_ctrl);
        chk("mload_idle", 32'(req_ready), 1);
`endif

        // reset on 3rd payload beat of an 8-beat MPUT
        expect_beat(32'h18480302, 1'b0);
        expect_beat(32'h00000400, 1'b0);
        for (int k = 0; k < 8; k++) begin
            wq.push_back(32'hB0000000 + 32'(k));
            expect_beat(32'hB0000000 + 32'(k), k == 7);
        end
        send_req(3'd4, 1'b1, 6'h02, 12'h000, 4'd3, 32'h400, 32'h0);
        hs_cnt = 0;
        for (int k = 0; k < 50 && hs_cnt < 5; k++) begin
            @(negedge clk_ctrl);
            if (m_TVALID && m_TREADY) hs_cnt++;
        end
        chk("rst_beat_reached", 32'(hs_cnt), 32'd5);
        #1;
        clk_ctrl_rst = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(m_TVALID), 0);
        chk("midrst_tlast", 32'(m_TLAST), 0);
        repeat (2) @(negedge clk_ctrl);
        exp_q.delete();
        wq.delete();
        chk("midrst_req_ready", 32'(req_ready), 0);
        @(negedge clk_ctrl);
        clk_ctrl_rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(req_ready), 1);
        repeat (3) @(negedge clk_ctrl);
        chk("midrst_no_trailing", 32'(m_TVALID), 0);

        // recovery after reset
        wq.push_back(32'h12345678);
        expect_beat(32'h08480000, 1'b0);
        expect_beat(32'h12345678, 1'b1);
        send_req(3'd4, 1'b0, 6'h00, 12'h000, 4'd0, 32'h0, 32'h0);
        wait_empty(50);
        repeat (2) @(negedge clk_ctrl);
        chk("recover_idle", 32'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
